// File: rtl/calc_operand_sequencer.sv
// Operand/opcode capture sequencer for the signed calculator: loads A, B and opcode from a
// shared bus on load edges, runs the ALU for EXEC_CYCLES and holds the result until acked.
module calc_operand_sequencer #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned OPW         = 3,
    parameter int unsigned RESW        = 8,
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ack,
    input  logic             clr,
    input  logic [RESW-1:0]  alu_res,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [OPW-1:0]   op,
    output logic             alu_en,
    output logic [RESW-1:0]  result,
    output logic             result_valid,
    output logic             busy
);

    localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    state_t           state;
    logic             load_q;
    logic [CNT_W-1:0] cnt;
    logic             ld_edge;

    // A held load level captures only once.
    assign ld_edge = load & ~load_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_A;
            load_q       <= 1'b0;
            cnt          <= '0;
            a            <= '0;
            b            <= '0;
            op           <= '0;
            alu_en       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            load_q <= load;
            if (clr) begin
                // Abort drops any same-cycle load edge; captured values and result survive.
                state  <= S_A;
                alu_en <= 1'b0;
                cnt    <= '0;
                busy   <= 1'b0;
            end else begin
                if (ack) begin
                    result_valid <= 1'b0;
                end
                case (state)
                    S_A: begin
                        if (ld_edge) begin
                            a            <= data_in;
                            result_valid <= 1'b0;
                            busy         <= 1'b1;
                            state        <= S_B;
                        end
                    end
                    S_B: begin
                        if (ld_edge) begin
                            b     <= data_in;
                            state <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (ld_edge) begin
                            op     <= data_in[OPW-1:0];
                            cnt    <= '0;
                            alu_en <= 1'b1;
                            state  <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        // Final exec cycle: latching result overrides a same-cycle ack.
                        if (cnt == CNT_LAST) begin
                            result       <= alu_res;
                            result_valid <= 1'b1;
                            alu_en       <= 1'b0;
                            busy         <= 1'b0;
                            cnt          <= '0;
                            state        <= S_A;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= S_A;
                        alu_en <= 1'b0;
                        busy   <= 1'b0;
                        cnt    <= '0;
                    end
                endcase
            end
        end
    end

endmodule
